// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the multi-lane packing / unpacking FIFO pair.
package fifo_pack_pkg;

   localparam int DATA_W     = 80;
   localparam int PUSH_LANES = 9;
   localparam int POP_LANES  = 6;

   typedef logic [DATA_W-1:0] entry_t;

   // Leading-ones count of valid & ready, starting at lane 0.
   function automatic int prefix_count(input logic [31:0] valid, input logic [31:0] ready);
      int   cnt;
      logic run;
      cnt = 0;
      run = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (run && valid[i] && ready[i]) cnt++;
         else run = 1'b0;
      end
      return cnt;
   endfunction

endpackage

// File: rtl/fifo_unpack_store.sv
// Circular entry store: IN_LANES write ports and OUT_LANES read ports,
// each addressed as base pointer plus lane offset (wrapping mod DEPTH).
module fifo_unpack_store #(
   parameter int DATA_W    = fifo_pack_pkg::DATA_W,
   parameter int IN_LANES  = 6,
   parameter int OUT_LANES = 9,
   parameter int DEPTH     = 16,
   parameter int PTR_W     = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [IN_LANES-1:0]           wr_en,
   input  logic [PTR_W-1:0]              wr_base,
   input  logic [IN_LANES*DATA_W-1:0]    wr_data,
   input  logic [PTR_W-1:0]              rd_base,
   output logic [OUT_LANES*DATA_W-1:0]   rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array is reset on purpose so out_data reads zero after reset;
   // large RAM-style stores are normally left unreset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      end else begin
         for (int i = 0; i < IN_LANES; i++) begin
            if (wr_en[i]) mem[wr_base + PTR_W'(i)] <= wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar k = 0; k < OUT_LANES; k++) begin : g_rd
      assign rd_data[k*DATA_W +: DATA_W] = mem[rd_base + PTR_W'(k)];
   end

endmodule

// File: rtl/fifo_unpack_d.sv
// Bundle-in, multi-lane-out FIFO. Optional entry counters with
// `define FIFO_UNPACK_STATS_EN.
module fifo_unpack_d
   import fifo_pack_pkg::prefix_count;
#(
   parameter int DATA_W    = fifo_pack_pkg::DATA_W,
   parameter int IN_LANES  = 6,
   parameter int OUT_LANES = 9,
   parameter int DEPTH     = 16,
   parameter int CNT_W     = $clog2(IN_LANES + 1),
   parameter int OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          test_en,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [CNT_W-1:0]              in_count,
   input  logic [IN_LANES*DATA_W-1:0]    in_data,
   output logic [OUT_LANES-1:0]          out_valid,
   input  logic [OUT_LANES-1:0]          out_ready,
   output logic [OUT_LANES*DATA_W-1:0]   out_data,
   output logic [OCC_W-1:0]              occupancy,
   output logic                          err_sticky
`ifdef FIFO_UNPACK_STATS_EN
   ,
   output logic [31:0]                   stat_in_entries,
   output logic [31:0]                   stat_out_entries
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]     rd_ptr, wr_ptr;
   logic [OUT_LANES-1:0] hit;
   logic [IN_LANES-1:0]  wr_en;
   logic [OCC_W-1:0]     push_cnt, pop_cnt;
   logic                 in_fire, over, gap_err;
   logic                 unused_test_en;

   assign unused_test_en = test_en;

   // Credit comes from registered occupancy only; pops this cycle do not help.
   assign in_ready = (occupancy <= OCC_W'(DEPTH - IN_LANES));
   assign in_fire  = in_valid & in_ready;
   assign over     = (in_count > CNT_W'(IN_LANES));

   always_comb begin
      out_valid = '0;
      for (int k = 0; k < OUT_LANES; k++) out_valid[k] = (k < int'(occupancy));
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      push_cnt = '0;
      wr_en    = '0;
      if (in_fire) push_cnt = over ? OCC_W'(IN_LANES) : OCC_W'(in_count);
      for (int i = 0; i < IN_LANES; i++) wr_en[i] = (i < int'(push_cnt));
      hit     = out_valid & out_ready;
      pop_cnt = OCC_W'(prefix_count(32'(out_valid), 32'(out_ready)));
      // Lane pop_cnt is the first gap; any hit at or above it is out of prefix.
      gap_err = |(hit >> pop_cnt);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         occupancy  <= '0;
         err_sticky <= 1'b0;
      end else begin
         wr_ptr    <= wr_ptr + PTR_W'(push_cnt);
         rd_ptr    <= rd_ptr + PTR_W'(pop_cnt);
         occupancy <= occupancy + push_cnt - pop_cnt;
         if ((in_fire && over) || gap_err) err_sticky <= 1'b1;
      end
   end

`ifdef FIFO_UNPACK_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_in_entries  <= '0;
         stat_out_entries <= '0;
      end else begin
         stat_in_entries  <= stat_in_entries + 32'(push_cnt);
         stat_out_entries <= stat_out_entries + 32'(pop_cnt);
      end
   end
`endif

   fifo_unpack_store #(
      .DATA_W    (DATA_W),
      .IN_LANES  (IN_LANES),
      .OUT_LANES (OUT_LANES),
      .DEPTH     (DEPTH),
      .PTR_W     (PTR_W)
   ) u_store (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_base (wr_ptr),
      .wr_data (in_data),
      .rd_base (rd_ptr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_fifo_unpack_d.sv
// Directed and scoreboarded bench for fifo_unpack_d; stats invariant is
// checked each cycle when FIFO_UNPACK_STATS_EN is defined.
module tb_fifo_unpack_d;

   localparam int DW    = 80;
   localparam int IL    = 6;
   localparam int OL    = 9;
   localparam int CNT_W = 3;
   localparam int OCC_W = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              test_en;
   logic              in_valid;
   logic              in_ready;
   logic [CNT_W-1:0]  in_count;
   logic [IL*DW-1:0]  in_data;
   logic [OL-1:0]     out_valid;
   logic [OL-1:0]     out_ready;
   logic [OL*DW-1:0]  out_data;
   logic [OCC_W-1:0]  occupancy;
   logic              err_sticky;
`ifdef FIFO_UNPACK_STATS_EN
   logic [31:0]       stat_in_entries;
   logic [31:0]       stat_out_entries;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   fifo_unpack_d dut (
      .clk              (clk),
      .reset            (reset),
      .test_en          (test_en),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_count         (in_count),
      .in_data          (in_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .occupancy        (occupancy),
      .err_sticky       (err_sticky)
`ifdef FIFO_UNPACK_STATS_EN
      ,
      .stat_in_entries  (stat_in_entries),
      .stat_out_entries (stat_out_entries)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] lane(input int k);
      return 128'(out_data[k*DW +: DW]);
   endfunction

   task automatic check_lanes(input string tag, input int n, input int v [OL]);
      for (int k = 0; k < n; k++) check($sformatf("%s_lane%0d", tag, k), lane(k), 128'(v[k]));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
`ifdef FIFO_UNPACK_STATS_EN
      check("stats_inv", 128'(stat_in_entries - stat_out_entries), 128'(32'(occupancy)));
`endif
   endtask

   task automatic set_bundle(input int cnt, input int base);
      in_valid = 1'b1;
      in_count = CNT_W'(cnt);
      for (int i = 0; i < IL; i++) in_data[i*DW +: DW] = DW'(base + i);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = '0;
      reset     = 1'b1;
      #2;
      step();
      reset = 1'b0;
   endtask

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] v;
   int            exp_l [OL];
   int            occ_m, r, m, cnt, n, sent;
   logic [OL-1:0] exp_v;

   initial begin
      reset     = 1'b1;
      test_en   = 1'b0;
      in_valid  = 1'b0;
      in_count  = '0;
      in_data   = '0;
      out_ready = '0;
      #12;
      check("rst_occ", 128'(occupancy), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_err", 128'(err_sticky), 128'(0));
      check("rst_data0", lane(0), 128'(0));
      check("rst_data8", lane(8), 128'(0));
      step();
      reset = 1'b0;

      // One bundle of six, consumer fully ready.
      set_bundle(6, 1);
      out_ready = 9'h1FF;
      step();
      in_valid = 1'b0;
      check("t1_valid", 128'(out_valid), 128'(9'b000111111));
      check("t1_occ", 128'(occupancy), 128'(6));
      exp_l = '{1, 2, 3, 4, 5, 6, 0, 0, 0};
      check_lanes("t1", 6, exp_l);
      step();
      check("t1_drained_occ", 128'(occupancy), 128'(0));
      check("t1_drained_valid", 128'(out_valid), 128'(0));

      // Fill until in_ready drops, then pop across the pointer wrap.
      out_ready = '0;
      set_bundle(6, 11);
      step();
      check("t2_occ6", 128'(occupancy), 128'(6));
      check("t2_rdy6", 128'(in_ready), 128'(1));
      set_bundle(6, 21);
      step();
      check("t2_occ12", 128'(occupancy), 128'(12));
      check("t2_rdy12", 128'(in_ready), 128'(0));
      set_bundle(6, 31);
      step();
      check("t2_held_occ", 128'(occupancy), 128'(12));
      exp_l = '{11, 12, 13, 14, 15, 16, 21, 22, 23};
      check_lanes("t2_full", 9, exp_l);
      out_ready = 9'h1FF;
      step();
      check("t2_pop9_occ", 128'(occupancy), 128'(3));
      check("t2_pop9_rdy", 128'(in_ready), 128'(1));
      out_ready = '0;
      step();
      in_valid = 1'b0;
      check("t2_wrap_occ", 128'(occupancy), 128'(9));
      check("t2_wrap_valid", 128'(out_valid), 128'(9'h1FF));
      exp_l = '{24, 25, 26, 31, 32, 33, 34, 35, 36};
      check_lanes("t2_wrap", 9, exp_l);

      // Prefix pop of 3 with a simultaneous write.
      out_ready = 9'b000000111;
      set_bundle(6, 41);
      step();
      in_valid = 1'b0;
      check("t3_occ", 128'(occupancy), 128'(12));
      check("t3_err", 128'(err_sticky), 128'(0));
      exp_l = '{31, 32, 33, 34, 35, 36, 41, 42, 43};
      check_lanes("t3", 9, exp_l);

      // Non-contiguous ready: only lane 0 pops, error latches.
      out_ready = 9'b000000101;
      step();
      check("t4_occ", 128'(occupancy), 128'(11));
      check("t4_err", 128'(err_sticky), 128'(1));
      check("t4_lane0", lane(0), 128'(32));
      out_ready = '0;
      step();
      check("t4_err_hold", 128'(err_sticky), 128'(1));
      check("t4_occ_hold", 128'(occupancy), 128'(11));

      // Asynchronous reset mid-operation.
      reset = 1'b1;
      #2;
      check("t5_occ", 128'(occupancy), 128'(0));
      check("t5_valid", 128'(out_valid), 128'(0));
      check("t5_err", 128'(err_sticky), 128'(0));
      check("t5_rdy", 128'(in_ready), 128'(1));
      check("t5_data0", lane(0), 128'(0));
      step();
      reset = 1'b0;

      // Zero-count handshake, then an over-count bundle.
      set_bundle(0, 0);
      step();
      check("t6_zero_occ", 128'(occupancy), 128'(0));
      check("t6_zero_err", 128'(err_sticky), 128'(0));
      set_bundle(7, 51);
      step();
      in_valid = 1'b0;
      check("t6_clamp_occ", 128'(occupancy), 128'(6));
      check("t6_clamp_err", 128'(err_sticky), 128'(1));
      check("t6_clamp_valid", 128'(out_valid), 128'(9'b000111111));
      exp_l = '{51, 52, 53, 54, 55, 56, 0, 0, 0};
      check_lanes("t6", 6, exp_l);

      // Scoreboarded random stream with a reset pulse part way through.
      do_reset();
      sent = 0;
      for (int cyc = 0; cyc < 2000 && sent < 100; cyc++) begin
         if (cyc == 15) begin
            do_reset();
            check("rnd_rst_occ", 128'(occupancy), 128'(0));
            check("rnd_rst_valid", 128'(out_valid), 128'(0));
            exp_q.delete();
            sent = 0;
         end
         occ_m = exp_q.size();
         exp_v = (occ_m >= OL) ? '1 : OL'((32'd1 << occ_m) - 1);
         check("rnd_occ", 128'(occupancy), 128'(occ_m));
         check("rnd_valid", 128'(out_valid), 128'(exp_v));
         check("rnd_rdy", 128'(in_ready), 128'(occ_m <= 10));
         cnt = (cyc % 11 == 5) ? 7 : int'($urandom_range(0, 6));
         in_valid = 1'b1;
         in_count = CNT_W'(cnt);
         for (int i = 0; i < IL; i++) begin
            v = DW'({$urandom, $urandom, $urandom});
            in_data[i*DW +: DW] = v;
         end
         r = int'($urandom_range(0, OL));
         out_ready = OL'((32'd1 << r) - 1);
         m = (r < occ_m) ? r : occ_m;
         for (int k = 0; k < m; k++) check($sformatf("rnd_pop%0d", k), lane(k), 128'(exp_q[k]));
         for (int k = 0; k < m; k++) void'(exp_q.pop_front());
         if (occ_m <= 10) begin
            n = (cnt > IL) ? IL : cnt;
            for (int i = 0; i < n; i++) exp_q.push_back(in_data[i*DW +: DW]);
            sent += n;
         end
         step();
      end
      in_valid = 1'b0;
      check("rnd_sent_all", 128'(sent >= 100), 128'(1));
      out_ready = 9'h1FF;
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         occ_m = exp_q.size();
         check("drain_occ", 128'(occupancy), 128'(occ_m));
         m = (occ_m < OL) ? occ_m : OL;
         for (int k = 0; k < m; k++) check($sformatf("drain_pop%0d", k), lane(k), 128'(exp_q[k]));
         for (int k = 0; k < m; k++) void'(exp_q.pop_front());
         step();
      end
      check("drain_done", 128'(exp_q.size()), 128'(0));
      check("drain_occ_final", 128'(occupancy), 128'(0));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fifo_unpack_d.md
Name: fifo_unpack_d

Overview:
- Transmit-side companion to the multi-lane packing FIFO.
- Accepts one wide bundle per handshake, carrying 0..IN_LANES entries with a count.
- Buffers entries in order in a circular entry store.
- Presents them as OUT_LANES per-lane valid/ready outputs in prefix order (lane 0 is always oldest), ready to feed a multi-lane push interface directly.

Parameters:
- DATA_W, 80, width of one entry
- IN_LANES, 6, max entries per input bundle
- OUT_LANES, 9, output lanes
- DEPTH, 16, entry store size; power of 2, >= max(IN_LANES, OUT_LANES)
- CNT_W, $clog2(IN_LANES+1), width of in_count
- OCC_W, $clog2(DEPTH+1), width of occupancy

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- test_en  in  1  scan enable; no functional effect
- in_valid  in  1  bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_count  in  CNT_W  number of valid entries in the bundle; lane 0 upward
- in_data  in  IN_LANES*DATA_W  entry i in bits [i*DATA_W +: DATA_W]
- out_valid  out  OUT_LANES  per-lane valid
- out_ready  in  OUT_LANES  per-lane ready
- out_data  out  OUT_LANES*DATA_W  lane k carries the entry at rd_ptr+k
- occupancy  out  OCC_W  entries currently stored
- err_sticky  out  1  protocol error seen; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert by the integrator): rd_ptr=0, wr_ptr=0, occupancy=0, err_sticky=0.
  - Outputs during/after reset: out_valid=0, in_ready=1, out_data=0 (store cleared).
- in_ready = (DEPTH - occupancy) >= IN_LANES.
  - Computed from registered occupancy only; no same-cycle credit from pops.
- Write on in_valid & in_ready:
  - n = min(in_count, IN_LANES); store[wr_ptr+i] <= in_data lane i for i<n; wr_ptr += n, mod DEPTH.
  - in_count=0 is a legal no-op handshake.
  - in_count>IN_LANES: clamp to IN_LANES and set err_sticky.
- out_valid[k] = (k < occupancy); out_data lane k = store[(rd_ptr+k) mod DEPTH], combinational from registers.
- Pop count m = number of leading lanes k=0.. with out_valid[k] & out_ready[k], stopping at the first lane where either is low.
  - rd_ptr += m mod DEPTH.
- Prefix rule: consumer ready must be prefix-contiguous.
  - Any lane j with out_valid[j] & out_ready[j] after a gap is not consumed and sets err_sticky.
- Same cycle write and pop: occupancy_next = occupancy + n - m; the written data is not visible until the next cycle.
  - Latency: a bundle accepted at edge N appears on out lanes in cycle N+1.
- Full: occupancy > DEPTH-IN_LANES deasserts in_ready; no overwrite is possible.
- Empty: all out_valid=0; out_data content is don't-care.
- Pointer wrap: a bundle or pop span crossing index DEPTH-1 wraps to 0 seamlessly.
- Reset mid-operation: all buffered entries are discarded; no partial pops.

Optional Feature:
- Macro: FIFO_UNPACK_STATS_EN.
- Defined: adds outputs stat_in_entries[31:0] and stat_out_entries[31:0].
  - They accumulate n and m respectively, wrapping at 2^32, and reset to 0.
  - Invariant at all times: stat_in - stat_out == occupancy (mod 2^32).
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_pack_pkg holds:
  - entry_t (logic [DATA_W-1:0]);
  - helper function prefix_count(valid, ready), returning the leading-ones count of valid & ready, shared with the packing FIFO;
  - localparam defaults DATA_W=80, PUSH_LANES=9, POP_LANES=6.
- One natural sub-module: fifo_unpack_store.
  - Contains the DEPTH-entry register array with IN_LANES write ports and OUT_LANES read ports, addressed by base pointer plus lane offset.
  - Pointer and occupancy logic stay in the top.

Test Plan:
- After reset, one bundle in_count=6, data 1..6, all out_ready=1 -> cycle+1: out_valid=9'b000111111, lanes 0..5 = 1..6; next cycle occupancy=0.
- Three bundles of 6 with out_ready=0 -> occupancy 6, 12; in_ready drops when occupancy=12 (free 4 < 6) and the third bundle is held; with out_ready=9'h1FF, 9 entries pop in order, the third bundle is accepted, and the order is preserved across pointer wrap.
- Store occupancy 9, out_ready=9'b000000111 -> m=3, lanes show entries 4..12 next cycle; err_sticky stays 0.
- Store occupancy 9, out_ready=9'b000000101 -> m=1, err_sticky=1 and stays 1 until reset.
- in_count=0 with in_valid -> handshake completes and occupancy is unchanged; in_count=7 -> 6 entries written and err_sticky=1.
- Random 100 entries with random prefix readies and a reset pulse mid-run -> post-reset occupancy=0 and out_valid=0; the received sequence equals the sent sequence since reset. With FIFO_UNPACK_STATS_EN, the counter invariant is checked every cycle.
